// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory model terminating one interconnect port.
// Accepts INCR/FIXED write and read bursts of 4-byte beats into a word array
// and returns B/R responses with the transaction ID echoed.
// Optional build macro AXI_RESP_STALL_EN: a 16-bit LFSR injects wready stalls
// and delays rvalid assertion to exercise initiator backpressure handling.
module axi_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    // write address channel
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data channel
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response channel
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    // read address channel
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read data channel
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Only the word-index bits of the addresses matter; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[ADDR_W-1:IDX_W+2], awaddr[1:0],
                                araddr[ADDR_W-1:IDX_W+2], araddr[1:0]};

    // ------------------------------------------------------------------
    // Stall source: high means "hold off" in the coming cycle
    // ------------------------------------------------------------------
    logic stall_next;

`ifdef AXI_RESP_STALL_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_next = lfsr_next[0];

    // Free-running LFSR, reseeded by reset.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) lfsr <= 16'hACE1;
        else              lfsr <= lfsr_next;
    end
`else
    assign stall_next = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t          w_state, w_next;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_cnt;
    logic [7:0]        w_len;
    logic              w_fixed;
    logic              w_err;
    logic              w_nowr;
    logic              aw_hs, w_hs, b_hs, w_last_beat;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign b_hs        = bvalid && bready;
    assign w_last_beat = (w_cnt == w_len);

    // Write FSM state register.
    always_ff @(posedge axi_aclk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values;
        // a blocking = here would let later readers in the same edge see new data.
        if (!axi_aresetn) w_state <= W_IDLE;
        else              w_state <= w_next;
    end

    // Write FSM next-state logic.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next unassigned,
        // which would otherwise infer a latch.
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)                w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat)  w_next = W_RESP;
            W_RESP:  if (b_hs)                 w_next = W_IDLE;
            default:                           w_next = W_IDLE;
        endcase
    end

    // Registered write-channel outputs and burst bookkeeping.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_idx   <= '0;
            w_cnt   <= '0;
            w_len   <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
            w_nowr  <= 1'b0;
        end else begin
            awready <= (w_next == W_IDLE);
            wready  <= (w_next == W_DATA) && !stall_next;
            bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                bid     <= awid;
                w_idx   <= awaddr[IDX_W+1:2];
                w_cnt   <= '0;
                w_len   <= awlen;
                w_fixed <= (awburst == BURST_FIXED);
                w_nowr  <= !burst_ok(awburst);
                w_err   <= (awsize != SIZE_4B) || !burst_ok(awburst);
            end
            if (w_hs) begin
                // A misplaced wlast poisons the response but never shortens the burst.
                if (wlast != w_last_beat) w_err <= 1'b1;
                if (w_last_beat) begin
                    bresp <= (w_err || (wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_cnt <= w_cnt + 8'd1;
                    if (!w_fixed) w_idx <= w_idx + 1'b1;
                end
            end
        end
    end

    // Byte-masked array write; unsupported burst types write nothing.
    always_ff @(posedge axi_aclk) begin
        // NOTE: the array has no reset on purpose -- contents survive reset.
        if (axi_aresetn && w_hs && !w_nowr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t          r_state, r_next;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_beat;
    logic [7:0]        r_len;
    logic              r_fixed;
    logic              r_err;
    logic              ar_hs, r_hs, ar_bad;

    // Beat to present next (fresh burst, following beat, or a delayed one).
    logic              ld_want, ld_go;
    logic [IDX_W-1:0]  ld_idx;
    logic [7:0]        ld_beat;
    logic [7:0]        ld_len;
    logic              ld_err;

    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign ar_bad = (arsize != SIZE_4B) || !burst_ok(arburst);
    assign ld_go  = ld_want && !stall_next;

    // Read FSM state register.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) r_state <= R_IDLE;
        else              r_state <= r_next;
    end

    // Read FSM next-state logic.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)          r_next = R_DATA;
            R_DATA:  if (r_hs && rlast)  r_next = R_IDLE;
            default:                     r_next = R_IDLE;
        endcase
    end

    // Select which beat (if any) should be loaded onto the R channel.
    always_comb begin
        ld_want = 1'b0;
        ld_idx  = r_idx;
        ld_beat = r_beat;
        ld_len  = r_len;
        ld_err  = r_err;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    ld_want = 1'b1;
                    ld_idx  = araddr[IDX_W+1:2];
                    ld_beat = '0;
                    ld_len  = arlen;
                    ld_err  = ar_bad;
                end
            end
            R_DATA: begin
                if (r_hs && !rlast) begin
                    ld_want = 1'b1;
                    ld_idx  = r_fixed ? r_idx : r_idx + 1'b1;
                    ld_beat = r_beat + 8'd1;
                end else if (!rvalid) begin
                    ld_want = 1'b1;
                end
            end
            default: ld_want = 1'b0;
        endcase
    end

    // Registered read-channel outputs; the array is read here so a same-cycle
    // write to the same word is seen by the next burst, not this beat.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_idx   <= '0;
            r_beat  <= '0;
            r_len   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                rid     <= arid;
                r_len   <= arlen;
                r_fixed <= (arburst == BURST_FIXED);
                r_err   <= ar_bad;
            end
            if (ld_want) begin
                r_idx  <= ld_idx;
                r_beat <= ld_beat;
            end
            if (ld_go) begin
                rvalid <= 1'b1;
                rdata  <= ld_err ? '0 : mem[ld_idx];
                rresp  <= ld_err ? RESP_SLVERR : RESP_OKAY;
                rlast  <= (ld_beat == ld_len);
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave memory model: terminates one downstream port of the testbench AXI interconnect.
- Accepts write and read bursts (INCR/FIXED, 4-byte beats) into an internal word array and returns B/R responses with ID echo.
- Used as the responder behind each interconnect slot so initiator-side traffic can be checked end to end.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed 4-byte beats.
- ID_W, 4, transaction ID width.
- MEM_DEPTH, 1024, words in array; power of two.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  synchronous active-low reset
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/8/3/2/1  write address channel
- awready  out  1  write address ready
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel
- wready  out  1  write data ready
- bid/bresp/bvalid  out  ID_W/2/1  write response
- bready  in  1  response ready
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/8/3/2/1  read address channel
- arready  out  1  read address ready
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel
- rready  in  1  read data ready

Behaviour:
- All outputs registered. While axi_aresetn=0 at a clock edge: every output is 0, both FSMs are in IDLE, memory contents are preserved.
- awready and arready rise on the first edge after reset release.
- Word index = addr[log2(MEM_DEPTH)+1:2]. Upper bits are ignored, so addressing wraps modulo MEM_DEPTH.
- Write and read FSMs are independent and each has one outstanding transaction.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE (awready=1): on awvalid, capture awid, addr, len and burst; set beat counter to 0; next cycle awready=0, wready=1.
  - W_DATA: each wvalid&wready beat writes bytes with wstrb[i]=1 only.
  - INCR: word index +1 per beat. FIXED: index held.
  - On the beat where counter==len: wready=0 and bvalid=1 with bid=captured id on the next cycle (1-cycle latency).
  - W_RESP: hold bid/bresp/bvalid stable until bready. On the handshake, bvalid=0 and awready=1 next cycle.
- bresp=SLVERR (2'b10) if any of:
  - awsize!=2;
  - awburst=WRAP or reserved (in both cases no memory writes occur);
  - wlast mismatches the beat position (memory writes still occur).
  Otherwise OKAY.
  - The beat count is always awlen+1 regardless of wlast.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE (arready=1): on arvalid, capture arid, addr, len and burst; next cycle arready=0, rvalid=1, rdata=mem[index], rid=arid, rlast=(len==0).
  - R_DATA: rid/rdata/rresp/rlast are held stable while rvalid&!rready.
  - On each handshake, the next beat's data is presented the following cycle. INCR advances the index; FIXED holds it.
  - After the handshake on the rlast beat: rvalid=0, arready=1 next cycle.
  - Gap between bursts: 1 idle cycle.
- Read error: arsize!=2 or non INCR/FIXED burst gives rresp=SLVERR and rdata=0 on all beats; the beat count is still arlen+1.
- Read/write collision on the same word in the same cycle: the read returns the old value; the write lands.
- Reset mid-burst: the transaction is abandoned with no response; beats already written stay in memory.

Optional Feature:
- Macro AXI_RESP_STALL_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1, reset to seed, advances every cycle) gates readiness.
  - wready is forced 0 and the next rvalid assertion is delayed whenever lfsr[0]=1.
  - An rvalid that is already asserted is never dropped before its handshake.
- When not defined: no stalls; timing exactly as above.

Test Plan:
- INCR write: awaddr=0x10, awlen=3, data 0x11..0x44, wstrb=0xF; then INCR read of the same range → bresp=OKAY, bid echoed; rdata 0x11,0x22,0x33,0x44; rlast on beat 4 only; rid echoed.
- Byte strobes: write 0xAABBCCDD to 0x0, then 0x11223344 with wstrb=0x5 → read returns 0xAA22CC44.
- FIXED burst: awaddr=0x8, awlen=2, data 1,2,3 → mem[2]=3, mem[3] unchanged; FIXED read, arlen=1 → 3,3.
- Errors:
  - awburst=WRAP → bresp=2'b10 and memory unchanged.
  - arsize=1 → rresp=2'b10, rdata=0 for all arlen+1 beats.
  - wlast early on beat 1 of awlen=2 → SLVERR after exactly 3 beats.
- Backpressure/wrap: bready low 5 cycles, rready toggling → bvalid/rdata held stable; awaddr=MEM_DEPTH*4 writes word 0.
- Reset asserted mid read burst → next cycle all outputs 0; arready=1 one cycle after release; a new read completes normally.
